// File: rtl/wb_nco_bank.sv
// Wishbone-mapped bank of NCO channels: each channel has a phase accumulator with a
// shadowed tuning word, a square or pulse clock output and a saturating wrap counter.
module wb_nco_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          ACC_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0300
) (
  input  logic              clk_i,
  input  logic              ext_rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [3:0]        sel_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o,
  output logic [NUM_CH-1:0] nco_o
);

  localparam logic [31:0] WIN_SIZE   = 32'(NUM_CH * 16);
  localparam logic [1:0]  OFF_TUNING = 2'd0;
  localparam logic [1:0]  OFF_CTRL   = 2'd1;
  localparam logic [1:0]  OFF_PHASE  = 2'd2;
  localparam logic [1:0]  OFF_WRAPS  = 2'd3;

  // Bus handshake: a request is accepted when cyc_i&stb_i hit the window while no
  // response is showing and the port is armed; ack_o/err_o then pulse for one cycle
  // and the following cycle is always response-free.
  logic [31:0] rel_addr;
  logic        in_win;
  logic [2:0]  ch_sel;
  logic [1:0]  off_sel;
  logic        armed_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;
  logic        req;
  logic        phase_wr;
  logic        reg_wr;
  logic [31:0] rd_data;
  logic [31:0] rd_word [NUM_CH];

  assign rel_addr = addr_i - BASE_ADDR;
  assign in_win   = (addr_i >= BASE_ADDR) && (rel_addr < WIN_SIZE);
  assign ch_sel   = rel_addr[6:4];
  assign off_sel  = rel_addr[3:2];
  assign req      = cyc_i & stb_i & in_win & armed_q & ~ack_q & ~err_q;
  assign phase_wr = req & we_i & (off_sel == OFF_PHASE);
  assign reg_wr   = req & we_i & ~phase_wr;

  function automatic logic [ACC_WIDTH-1:0] lane_merge(input logic [ACC_WIDTH-1:0] old_v,
                                                      input logic [31:0]          wd,
                                                      input logic [3:0]           be);
    logic [31:0] v;
    v = 32'(old_v);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) v[8*k +: 8] = wd[8*k +: 8];
    end
    return v[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) rd_data = rd_word[i];
    end
  end

  // A transaction already on the bus when reset lifts is never answered; the port
  // arms only after it has seen the strobe low once.
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      if (!(cyc_i & stb_i)) armed_q <= 1'b1;
      ack_q <= req & ~phase_wr;
      err_q <= phase_wr;
      dat_q <= (req & ~we_i) ? rd_data : '0;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;
  assign rty_o = 1'b0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic                 hit;
    logic                 tune_wr;
    logic                 ctrl_wr;
    logic                 wraps_wr;
    logic                 pclr;
    logic                 ovf;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] shadow_nxt;
    logic [ACC_WIDTH-1:0] shadow_q;
    logic [ACC_WIDTH-1:0] active_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 en_q;
    logic                 mode_q;
    logic                 pend_q;
    logic                 nco_q;
    logic [15:0]          wraps_q;

    assign hit        = (ch_sel == 3'(g));
    assign tune_wr    = reg_wr & hit & (off_sel == OFF_TUNING);
    assign ctrl_wr    = reg_wr & hit & (off_sel == OFF_CTRL) & sel_i[0];
    assign wraps_wr   = reg_wr & hit & (off_sel == OFF_WRAPS);
    assign pclr       = ctrl_wr & dat_i[2];
    assign sum        = {1'b0, acc_q} + {1'b0, active_q};
    assign ovf        = en_q & ~pclr & sum[ACC_WIDTH];
    assign shadow_nxt = tune_wr ? lane_merge(shadow_q, dat_i, sel_i) : shadow_q;

    always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
        shadow_q <= '0;
        active_q <= '0;
        acc_q    <= '0;
        en_q     <= 1'b0;
        mode_q   <= 1'b0;
        pend_q   <= 1'b0;
        nco_q    <= 1'b0;
        wraps_q  <= '0;
      end else begin
        shadow_q <= shadow_nxt;
        if (pclr)      acc_q <= '0;
        else if (en_q) acc_q <= sum[ACC_WIDTH-1:0];
        // New tuning takes effect at a wrap so the current period completes cleanly.
        if (!en_q)              active_q <= shadow_nxt;
        else if (ovf && pend_q) active_q <= shadow_q;
        if (tune_wr && en_q)    pend_q <= 1'b1;
        else if (!en_q || ovf)  pend_q <= 1'b0;
        if (ctrl_wr) begin
          en_q   <= dat_i[0];
          mode_q <= dat_i[1];
        end
        nco_q <= en_q & (mode_q ? ovf : acc_q[ACC_WIDTH-1]);
        if (wraps_wr)                        wraps_q <= {15'd0, ovf};
        else if (ovf && wraps_q != 16'hFFFF) wraps_q <= wraps_q + 16'd1;
      end
    end

    assign nco_o[g]   = nco_q & en_q;
    assign rd_word[g] = (off_sel == OFF_TUNING) ? 32'(shadow_q) :
                        (off_sel == OFF_CTRL)   ? {30'd0, mode_q, en_q} :
                        (off_sel == OFF_PHASE)  ? 32'(acc_q) :
                                                  {16'd0, wraps_q};
  end

endmodule

// File: tb/tb_wb_nco_bank.sv
// Bench for wb_nco_bank: directed scenarios plus randomized register traffic, checked
// against a cycle-level arithmetic model of the channel bank.
module tb_wb_nco_bank;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h0000_0300;

  logic        clk;
  logic        ext_rst_i;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic [NCH-1:0] nco_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_nco_bank #(.NUM_CH(NCH), .ACC_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .ext_rst_i(ext_rst_i), .addr_i(addr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .sel_i(sel_i),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .nco_o(nco_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_shadow [NCH];
  logic [31:0] m_active [NCH];
  logic [31:0] m_acc    [NCH];
  bit          m_en     [NCH];
  bit          m_mode   [NCH];
  bit          m_pend   [NCH];
  bit          m_nco    [NCH];
  int unsigned m_wraps  [NCH];
  bit          m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic [31:0] m_rd_exp;
  int          m_last_edge;
  int          cyc_cnt;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = '0; m_active[c] = '0; m_acc[c] = '0;
      m_en[c] = 0; m_mode[c] = 0; m_pend[c] = 0; m_nco[c] = 0; m_wraps[c] = 0;
    end
    m_req = 0;
    m_rd_exp = '0;
  endtask

  always @(posedge clk) begin : model_step
    int          hit;
    int          off;
    logic [31:0] rel;
    bit          wr;
    bit          pclr;
    bit          ovf;
    logic [32:0] s;
    logic [31:0] old_shadow;
    bit          old_en;
    bit          old_pend;
    if (ext_rst_i) begin
      cyc_cnt++;
      hit = -1;
      off = 0;
      if (m_req) begin
        m_last_edge = cyc_cnt;
        rel = m_addr - BASE;
        m_rd_exp = '0;
        if (m_addr >= BASE && rel < 32'(16 * NCH)) begin
          hit = int'(rel >> 4);
          off = int'(rel[3:2]);
          case (off)
            0: m_rd_exp = m_shadow[hit];
            1: m_rd_exp = {30'd0, m_mode[hit], m_en[hit]};
            2: m_rd_exp = m_acc[hit];
            default: m_rd_exp = m_wraps[hit];
          endcase
        end
      end
      for (int c = 0; c < NCH; c++) begin
        wr = m_req && (hit == c) && m_we && (off != 2);
        pclr = wr && (off == 1) && m_sel[0] && m_dat[2];
        old_shadow = m_shadow[c];
        old_en = m_en[c];
        old_pend = m_pend[c];
        ovf = 0;
        m_nco[c] = old_en && (m_mode[c] ? 1'b0 : m_acc[c][31]);
        if (pclr) begin
          m_acc[c] = '0;
        end else if (old_en) begin
          s = 33'(m_acc[c]) + 33'(m_active[c]);
          ovf = s[32];
          m_acc[c] = s[31:0];
        end
        if (old_en && m_mode[c]) m_nco[c] = ovf;
        if (wr && off == 0) begin
          for (int k = 0; k < 4; k++)
            if (m_sel[k]) m_shadow[c][8*k +: 8] = m_dat[8*k +: 8];
        end
        if (!old_en) m_active[c] = m_shadow[c];
        else if (ovf && old_pend) m_active[c] = old_shadow;
        if (wr && off == 0 && old_en) m_pend[c] = 1;
        else if (!old_en || ovf) m_pend[c] = 0;
        if (wr && off == 1 && m_sel[0]) begin
          m_en[c] = m_dat[0];
          m_mode[c] = m_dat[1];
        end
        if (wr && off == 3) m_wraps[c] = ovf ? 1 : 0;
        else if (ovf && m_wraps[c] < 32'hFFFF) m_wraps[c] = m_wraps[c] + 1;
      end
      m_req = 0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] reg_addr(input int ch, input int off);
    return BASE + 32'(16 * ch) + 32'(4 * off);
  endfunction

  // Called at a negedge; drives one access, samples the response, returns one idle cycle later.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic ak,
                      output logic er);
    addr_i = a; we_i = w; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    m_addr = a; m_we = w; m_dat = d; m_sel = s; m_req = 1;
    @(negedge clk);
    rd = dat_o; ak = ack_o; er = err_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int off, input logic [31:0] d);
    logic [31:0] rd;
    logic ak, er;
    xfer(reg_addr(ch, off), 1'b1, d, 4'hF, rd, ak, er);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic ak, er;
    ext_rst_i = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    n_tests++;
    if (nco_o !== '0 || ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0 || rty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: nco=%h ack=%b err=%b dat=%h rty=%b, required all 0",
               nco_o, ack_o, err_o, dat_o, rty_o);
    end
    ext_rst_i = 1'b1;
    @(negedge clk);
    for (int off = 0; off < 4; off++) begin
      xfer(reg_addr(0, off), 1'b0, '0, 4'hF, rd, ak, er);
      n_tests++;
      if (rd !== 32'h0 || ak !== 1'b1 || er !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_reg off=%0d: dat=%h ack=%b err=%b, required 0/1/0", off, rd, ak, er);
      end
    end
  endtask

  task automatic test_square();
    logic [31:0] rd;
    logic ak, er;
    int hi, rises, e_en, e_dis;
    logic prev;
    cfg_write(0, 0, 32'h4000_0000);
    cfg_write(0, 1, 32'h4);
    cfg_write(0, 3, 32'h0);
    cfg_write(0, 1, 32'h1);
    e_en = m_last_edge;
    prev = nco_o[0];
    hi = 0; rises = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_tests++;
      if (nco_o[0] !== (m_nco[0] & m_en[0])) begin
        n_fail++;
        $display("FAIL square_nco cyc=%0d: nco0=%b, required %b", i, nco_o[0], m_nco[0] & m_en[0]);
      end
      if (nco_o[0] === 1'b1) hi++;
      if (nco_o[0] === 1'b1 && prev === 1'b0) rises++;
      prev = nco_o[0];
    end
    n_tests++;
    if (hi != 8 || rises != 4) begin
      n_fail++;
      $display("FAIL square_shape: high=%0d rises=%0d in 16 cycles, required 8 and 4", hi, rises);
    end
    repeat ($urandom_range(0, 9)) @(negedge clk);
    cfg_write(0, 1, 32'h0);
    e_dis = m_last_edge;
    xfer(reg_addr(0, 3), 1'b0, '0, 4'hF, rd, ak, er);
    n_tests++;
    if (rd !== 32'((e_dis - e_en) / 4) || ak !== 1'b1) begin
      n_fail++;
      $display("FAIL square_wraps: wraps=%0d ack=%b, required %0d after %0d enabled cycles",
               rd, ak, (e_dis - e_en) / 4, e_dis - e_en);
    end
  endtask

  task automatic test_pulse();
    int hi, bad;
    logic prev;
    cfg_write(1, 0, 32'h8000_0000);
    cfg_write(1, 1, 32'h4);
    cfg_write(1, 1, 32'h3);
    @(negedge clk);
    prev = nco_o[1];
    hi = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (nco_o[1] !== (m_nco[1] & m_en[1])) begin
        n_fail++;
        $display("FAIL pulse_nco cyc=%0d: nco1=%b, required %b", i, nco_o[1], m_nco[1] & m_en[1]);
      end
      if (nco_o[1] === prev) bad++;
      if (nco_o[1] === 1'b1) hi++;
      prev = nco_o[1];
    end
    n_tests++;
    if (hi != 6 || bad != 0) begin
      n_fail++;
      $display("FAIL pulse_shape: high=%0d non_alternating=%0d in 12 cycles, required 6 and 0", hi, bad);
    end
  endtask

  task automatic test_retune();
    logic [31:0] rd;
    logic ak, er;
    int t_prev, gaps[$];
    bit seen;
    cfg_write(3, 0, 32'h1000_0000);
    cfg_write(3, 1, 32'h7);
    seen = 0; t_prev = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (nco_o[3] === 1'b1) begin seen = 1; t_prev = cyc_cnt; end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL retune_first_pulse: no pulse within 40 cycles, required one");
    end
    repeat (5) @(negedge clk);
    cfg_write(3, 0, 32'h2000_0000);
    for (int i = 0; i < 60 && gaps.size() < 3; i++) begin
      @(negedge clk);
      if (nco_o[3] === 1'b1) begin gaps.push_back(cyc_cnt - t_prev); t_prev = cyc_cnt; end
    end
    n_tests++;
    if (gaps.size() != 3) begin
      n_fail++;
      $display("FAIL retune_pulses: saw %0d pulses, required 3", gaps.size());
    end else begin
      n_tests += 2;
      if (gaps[0] != 16) begin
        n_fail++;
        $display("FAIL retune_old_rate: gap=%0d, required 16", gaps[0]);
      end
      if (gaps[1] != 8 || gaps[2] != 8) begin
        n_fail++;
        $display("FAIL retune_new_rate: gaps=%0d,%0d, required 8,8", gaps[1], gaps[2]);
      end
    end
    xfer(reg_addr(3, 0), 1'b0, '0, 4'hF, rd, ak, er);
    n_tests++;
    if (rd !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL retune_shadow: tuning=%h, required 20000000", rd);
    end
    cfg_write(3, 1, 32'h0);
  endtask

  task automatic test_err_window();
    logic [31:0] rd;
    logic ak, er;
    logic [31:0] bad_addr [2];
    xfer(reg_addr(2, 2), 1'b1, 32'hDEAD_BEEF, 4'hF, rd, ak, er);
    n_tests++;
    if (er !== 1'b1 || ak !== 1'b0) begin
      n_fail++;
      $display("FAIL phase_write_err: err=%b ack=%b, required 1/0", er, ak);
    end
    n_tests++;
    if (err_o !== 1'b0 || ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL phase_err_width: err=%b ack=%b one cycle later, required 0/0", err_o, ack_o);
    end
    bad_addr[0] = BASE + 32'(16 * NCH);
    bad_addr[1] = BASE - 32'd4;
    for (int j = 0; j < 2; j++) begin
      addr_i = bad_addr[j]; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_tests++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0) begin
          n_fail++;
          $display("FAIL out_of_window addr=%h: ack=%b err=%b dat=%h, required 0/0/0",
                   bad_addr[j], ack_o, err_o, dat_o);
        end
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_pclr_ovf();
    logic [31:0] rd;
    logic ak, er;
    int unsigned wraps_before;
    bit found;
    cfg_write(2, 1, 32'h0);
    cfg_write(2, 0, 32'h8000_0000);
    cfg_write(2, 1, 32'h4);
    cfg_write(2, 1, 32'h1);
    repeat (5) @(negedge clk);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (m_acc[2] == 32'h8000_0000) found = 1;
      else @(negedge clk);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL pclr_setup: accumulator never reached 80000000");
    end
    wraps_before = m_wraps[2];
    xfer(reg_addr(2, 1), 1'b1, 32'h4, 4'h1, rd, ak, er);
    xfer(reg_addr(2, 2), 1'b0, '0, 4'hF, rd, ak, er);
    n_tests++;
    if (rd !== 32'h0 || ak !== 1'b1) begin
      n_fail++;
      $display("FAIL pclr_phase: phase=%h ack=%b, required 0 and 1", rd, ak);
    end
    xfer(reg_addr(2, 3), 1'b0, '0, 4'hF, rd, ak, er);
    n_tests++;
    if (rd !== 32'(wraps_before)) begin
      n_fail++;
      $display("FAIL pclr_wraps: wraps=%0d, required %0d", rd, wraps_before);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    logic ak, er, w;
    int ch, off;
    for (int n = 0; n < 60; n++) begin
      ch = $urandom_range(0, NCH - 1);
      off = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (off == 1 && $urandom_range(0, 1) == 1) d = {29'd0, d[2:1], 1'b1};
      xfer(reg_addr(ch, off), w, d, 4'($urandom_range(0, 15)), rd, ak, er);
      n_tests++;
      if (ak !== !(w && off == 2) || er !== (w && off == 2)) begin
        n_fail++;
        $display("FAIL rand_resp n=%0d ch=%0d off=%0d we=%b: ack=%b err=%b, required %b/%b",
                 n, ch, off, w, ak, er, !(w && off == 2), w && off == 2);
      end
      if (!w) begin
        n_tests++;
        if (rd !== m_rd_exp) begin
          n_fail++;
          $display("FAIL rand_read n=%0d ch=%0d off=%0d: dat=%h, required %h", n, ch, off, rd, m_rd_exp);
        end
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
          n_tests++;
          if (nco_o[c] !== (m_nco[c] & m_en[c])) begin
            n_fail++;
            $display("FAIL rand_nco ch=%0d: nco=%b, required %b", c, nco_o[c], m_nco[c] & m_en[c]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic ak, er;
    bit seen;
    cfg_write(0, 0, 32'h4000_0000);
    cfg_write(0, 1, 32'h1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (nco_o[0] === 1'b1) seen = 1;
    end
    #2;
    ext_rst_i = 1'b0;
    model_clear();
    addr_i = reg_addr(1, 1); we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    #1;
    n_tests++;
    if (nco_o !== '0 || ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== '0 || !seen) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: nco=%h ack=%b err=%b dat=%h running=%b, required 0/0/0/0/1",
               nco_o, ack_o, err_o, dat_o, seen);
    end
    @(negedge clk);
    ext_rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (ack_o !== 1'b0 || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_after_reset cyc=%0d: ack=%b err=%b, required 0/0", i, ack_o, err_o);
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      for (int off = 0; off < 4; off++) begin
        xfer(reg_addr(c, off), 1'b0, '0, 4'hF, rd, ak, er);
        n_tests++;
        if (rd !== 32'h0 || ak !== 1'b1) begin
          n_fail++;
          $display("FAIL post_reset_reg ch=%0d off=%0d: dat=%h ack=%b, required 0 and 1", c, off, rd, ak);
        end
      end
    end
  endtask

  initial begin
    ext_rst_i = 1'b0;
    addr_i = '0; dat_i = '0; we_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; sel_i = 4'h0;
    cyc_cnt = 0; m_last_edge = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_square();
    test_pulse();
    test_retune();
    test_err_window();
    test_pclr_ovf();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
